dcache_controller: RTL and testbench
====================================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL take parameter NUM_LINES, default 256, meaning the number of direct-mapped 128-bit lines (power of two); IDX_W = log2(NUM_LINES) and TAG_W = 28 - IDX_W.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cpu_read, input, 1 bit: word load request.
REQ-005 The block SHALL have port cpu_write, input, 1 bit: word store request.
REQ-006 The block SHALL have port cpu_addr, input, 32 bits: byte address, where [31:4+IDX_W] is the tag, [3+IDX_W:4] is the index and [3:2] selects the word.
REQ-007 The block SHALL have port cpu_wdata, input, 32 bits: store data.
REQ-008 The block SHALL have port cpu_rdata, output, 32 bits: load data.
REQ-009 The block SHALL have port cpu_stall, output, 1 bit: request not complete; the CPU holds all request inputs stable while it is high.
REQ-010 The block SHALL have port mem_read, output, 1 bit: line read request to data memory.
REQ-011 The block SHALL have port mem_write, output, 1 bit: line write request to data memory.
REQ-012 The block SHALL have port mem_addr, output, 32 bits: line address, with [3:0] always 0.
REQ-013 The block SHALL have port mem_wdata, output, 128 bits: victim line for writeback.
REQ-014 The block SHALL have port mem_rdata, input, 128 bits: fill line, valid in the cycle mem_ready is high.
REQ-015 The block SHALL have port mem_ready, input, 1 bit: a one-cycle completion pulse from data memory.
REQ-016 The block SHALL have port hit_count, output, 32 bits: completed-hit counter.
REQ-017 The block SHALL have port miss_count, output, 32 bits: miss counter.

Function
REQ-018 Storage SHALL be, per line: valid, dirty, TAG_W tag bits and 128 data bits. Word k SHALL occupy data bits [32k+31:32k], with k = cpu_addr[3:2].
REQ-019 Request: req = cpu_read | cpu_write. If both inputs are high, the access SHALL be treated as a write.
REQ-020 Hit = valid[idx] & (tag[idx] == addr tag). Hit SHALL be evaluated combinationally, and only in state IDLE.
REQ-021 Read hit: cpu_rdata SHALL show the selected word in the same cycle with cpu_stall = 0 (zero-wait).
REQ-022 Write hit: the selected word SHALL be replaced at the next posedge and dirty[idx] SHALL be set to 1, with cpu_stall = 0.
REQ-023 cpu_stall SHALL equal req & ~(state == IDLE & hit), combinationally.
REQ-024 FSM states SHALL be IDLE, WB_REQ, WB_WAIT, FILL_REQ and FILL_WAIT.
REQ-025 In IDLE, a miss with valid & dirty victim SHALL transition to WB_REQ; any other miss SHALL transition to FILL_REQ; each miss SHALL increment miss_count once.
REQ-026 WB_REQ SHALL last one cycle, with mem_write = 1, mem_addr = {victim tag, idx, 4'b0} and mem_wdata = victim line; it SHALL then go to WB_WAIT.
REQ-027 WB_WAIT SHALL hold mem_wdata stable; on mem_ready it SHALL clear dirty[idx] and go to FILL_REQ.
REQ-028 FILL_REQ SHALL last one cycle, with mem_read = 1 and mem_addr = {cpu_addr[31:4], 4'b0}; it SHALL then go to FILL_WAIT.
REQ-029 FILL_WAIT: on mem_ready, the line SHALL be loaded from mem_rdata, with valid = 1, dirty = 0, tag written, and the state SHALL return to IDLE. The retried access SHALL then hit in the following cycle and be applied per REQ-021/REQ-022.
REQ-030 mem_read and mem_write SHALL be single-cycle pulses, never high together, and zero outside WB_REQ and FILL_REQ.
REQ-031 mem_addr SHALL hold its request value through the matching WAIT state; otherwise it SHALL be 0.
REQ-032 mem_ready SHALL be ignored in IDLE, WB_REQ and FILL_REQ.
REQ-033 No timeout SHALL exist: WAIT states SHALL hold indefinitely until mem_ready.
REQ-034 hit_count SHALL increment on each IDLE cycle with req & hit. Both counters SHALL wrap modulo 2^32.
REQ-035 cpu_rdata SHALL be 0 when no read hit is present.

Reset
REQ-036 When rst_n is low, the block SHALL asynchronously force: state = IDLE; all valid and dirty bits = 0; mem_read = mem_write = 0; mem_addr = 0; mem_wdata = 0; both counters = 0. Tag and data arrays SHALL not be cleared.
REQ-037 Reset asserted mid-transaction SHALL abandon the transaction. A stale mem_ready after reset release SHALL cause no state change.
REQ-038 During and immediately after reset, cpu_stall SHALL follow REQ-023, so any request after reset SHALL miss.

Verification
REQ-039 Cold read at 0x0000_0040 after reset SHALL produce: stall high; FILL_REQ with mem_read pulse of 1 cycle and mem_addr = 0x40; on mem_ready with mem_rdata = 0xDDDD_CCCC_BBBB_AAAA_..._4444_3333_2222_1111 (words 3..0), the next cycle SHALL give cpu_rdata = word 0 with stall 0; miss_count = 1 and hit_count = 1.
REQ-040 Write hit at 0x44 with data 0xCAFE_F00D followed by a read of 0x44 SHALL return 0xCAFE_F00D with zero stall in both cycles, and the dirty bit SHALL be set.
REQ-041 A dirty conflict miss at address 0x40 + 16·NUM_LINES SHALL produce: mem_write pulse with mem_addr = 0x40 and mem_wdata containing 0xCAFE_F00D in word 1; after mem_ready, a mem_read pulse for the new line; mem_read and mem_write SHALL never overlap.
REQ-042 Simultaneous cpu_read and cpu_write on a hit SHALL perform the write only.
REQ-043 rst_n pulsed low during FILL_WAIT, followed by a mem_ready pulse after release, SHALL leave state = IDLE, all lines invalid and counters = 0.
REQ-044 A delayed mem_ready (200 cycles) SHALL keep stall held high and mem_addr stable throughout, with no repeated request pulses.

Source files
------------

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back data cache controller with writeback/fill FSM
module dcache_controller #(
  parameter int NUM_LINES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  state_t state_q, state_d;

  // Valid/dirty are reset; tag and data arrays are deliberately left uncleared.
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [127:0]         data_arr [NUM_LINES];

  logic             req;
  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [1:0]       word_sel;
  logic [TAG_W-1:0] line_tag;
  logic [127:0]     line_data;
  logic             hit;
  logic             idle_hit;
  logic [31:0]      rd_word;
  logic [127:0]     wr_line;
  logic             do_write_hit;
  logic             do_fill;
  logic             do_wb_done;
  logic             miss_evt;

  assign req       = cpu_read | cpu_write;
  assign addr_tag  = cpu_addr[31:4+IDX_W];
  assign addr_idx  = cpu_addr[3+IDX_W:4];
  assign word_sel  = cpu_addr[3:2];
  assign line_tag  = tag_arr[addr_idx];
  assign line_data = data_arr[addr_idx];

  // Hit is only meaningful in IDLE; elsewhere the request is always stalled.
  assign hit       = valid_q[addr_idx] & (line_tag == addr_tag);
  assign idle_hit  = (state_q == IDLE) & hit;
  assign cpu_stall = req & ~idle_hit;

  // A simultaneous read+write is a write, so only a pure read returns data.
  assign cpu_rdata = (idle_hit & cpu_read & ~cpu_write) ? rd_word : 32'd0;

  assign do_write_hit = idle_hit & cpu_write;
  assign miss_evt     = (state_q == IDLE) & req & ~hit;
  assign do_wb_done   = (state_q == WB_WAIT) & mem_ready;
  assign do_fill      = (state_q == FILL_WAIT) & mem_ready;

  // Select the addressed word of the indexed line for loads.
  always_comb begin
    rd_word = 32'd0;
    case (word_sel)
      2'd0: rd_word = line_data[31:0];
      2'd1: rd_word = line_data[63:32];
      2'd2: rd_word = line_data[95:64];
      2'd3: rd_word = line_data[127:96];
      default: rd_word = 32'd0;
    endcase
  end

  // Merge store data into the indexed line for a write hit.
  always_comb begin
    wr_line = line_data;
    case (word_sel)
      2'd0: wr_line[31:0]   = cpu_wdata;
      2'd1: wr_line[63:32]  = cpu_wdata;
      2'd2: wr_line[95:64]  = cpu_wdata;
      2'd3: wr_line[127:96] = cpu_wdata;
      default: wr_line = line_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: misses go through optional writeback then fill; waits hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (miss_evt) begin
          if (valid_q[addr_idx] & dirty_q[addr_idx]) begin
            state_d = WB_REQ;
          end else begin
            state_d = FILL_REQ;
          end
        end
      end
      WB_REQ:    state_d = WB_WAIT;
      WB_WAIT:   if (mem_ready) state_d = FILL_REQ;
      FILL_REQ:  state_d = FILL_WAIT;
      FILL_WAIT: if (mem_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Memory-side outputs decode from state; the CPU holds cpu_addr stable so addresses stay fixed through the waits.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 128'd0;
    case (state_q)
      WB_REQ: begin
        mem_write = 1'b1;
        mem_addr  = {line_tag, addr_idx, 4'b0000};
        mem_wdata = line_data;
      end
      WB_WAIT: begin
        mem_addr  = {line_tag, addr_idx, 4'b0000};
        mem_wdata = line_data;
      end
      FILL_REQ: begin
        mem_read = 1'b1;
        mem_addr = {cpu_addr[31:4], 4'b0000};
      end
      FILL_WAIT: begin
        mem_addr = {cpu_addr[31:4], 4'b0000};
      end
      default: ;
    endcase
  end

  // Line status bits: set on fill, dirtied by write hits, cleaned by completed writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (do_fill) begin
        valid_q[addr_idx] <= 1'b1;
        dirty_q[addr_idx] <= 1'b0;
      end else if (do_wb_done) begin
        dirty_q[addr_idx] <= 1'b0;
      end else if (do_write_hit) begin
        dirty_q[addr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage: whole-line fill from memory or single-word store on a write hit.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      tag_arr[addr_idx]  <= addr_tag;
      data_arr[addr_idx] <= mem_rdata;
    end else if (do_write_hit) begin
      data_arr[addr_idx] <= wr_line;
    end
  end

  // Hit and miss counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (idle_hit & req) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_evt) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller
module tb_dcache_controller;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_CPU = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t         sb [$];
  logic [127:0] model [logic [31:0]];
  int           compared = 0;
  int           mismatched = 0;
  int           ready_delay = 0;
  bit           resp_en = 1'b1;
  int           kick_n = 0;
  int           kick_done = 0;

  dcache_controller #(.NUM_LINES(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic [127:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  // Pops one expectation for every memory request pulse and every completed CPU access.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_read || mem_write) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_mem: read=%0b write=%0b addr=%h expected no request",
                     mem_read, mem_write, mem_addr);
          end else begin
            e = sb.pop_front();
            chk("mem_kind", {30'd0, mem_write, mem_read},
                (e.kind == K_WR) ? 32'd2 : ((e.kind == K_RD) ? 32'd1 : 32'd0));
            chk("mem_addr", mem_addr, e.addr);
            if (e.kind == K_WR) chk128("mem_wdata", mem_wdata, e.data);
          end
        end
        if ((cpu_read || cpu_write) && !cpu_stall) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_cpu: addr=%h rdata=%h expected no completion", cpu_addr, cpu_rdata);
          end else begin
            e = sb.pop_front();
            chk("cpu_kind", e.kind, K_CPU);
            chk("cpu_rdata", cpu_rdata, e.data[31:0]);
          end
        end
      end
    end
  endtask

  // Data memory model: answers each request with a one-cycle mem_ready after ready_delay cycles.
  task automatic responder_loop();
    logic [31:0]  a;
    logic         w;
    logic [127:0] d;
    forever begin
      @(negedge clk);
      if (kick_done != kick_n) begin
        kick_done++;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        mem_rdata = '1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = '0;
      end else if (resp_en && rst_n && (mem_read || mem_write)) begin
        a = mem_addr;
        w = mem_write;
        d = mem_wdata;
        repeat (ready_delay) @(posedge clk);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        if (w) model[a] = d;
        else   mem_rdata = model.exists(a) ? model[a] : {4{a}};
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = '0;
      end
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit exp_miss, input logic [31:0] exp_rdata);
    int cyc;
    push(K_CPU, a, {96'd0, exp_rdata});
    @(posedge clk); #1;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    @(negedge clk);
    chk("first_stall", {31'd0, cpu_stall}, {31'd0, exp_miss});
    cyc = 0;
    while (cpu_stall && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (cpu_stall) chk("access_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad;
    rst_n     = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    model[32'h40]   = 128'hDDDDCCCC_BBBBAAAA_44443333_22221111;
    model[32'h1040] = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    model[32'h2050] = 128'h55550003_55550002_55550001_55550000;
    model[32'h3070] = 128'h73737373_72727272_71717171_70707070;
    fork
      monitor_loop();
      responder_loop();
    join_none

    // Reset state, and a request during reset must stall.
    repeat (2) @(posedge clk);
    #1;
    cpu_read = 1'b1;
    cpu_addr = 32'h40;
    @(negedge clk);
    chk("stall_in_reset", {31'd0, cpu_stall}, 32'd1);
    cpu_read = 1'b0;
    @(negedge clk);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    chk("rst_mem_rw", {30'd0, mem_write, mem_read}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk128("rst_mem_wdata", mem_wdata, 128'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cold read miss then fill.
    push(K_RD, 32'h40, '0);
    access(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, 32'h22221111);
    @(negedge clk);
    chk("cold_miss_count", miss_count, 32'd1);
    chk("cold_hit_count", hit_count, 32'd1);

    // Write hit then read-back, both zero wait.
    access(1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 1'b0, 32'd0);
    access(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h48, 32'd0, 1'b0, 32'hBBBBAAAA);
    access(1'b1, 1'b0, 32'h4C, 32'd0, 1'b0, 32'hDDDDCCCC);

    // Read and write together: write only, no read data.
    access(1'b1, 1'b1, 32'h48, 32'h12345678, 1'b0, 32'd0);
    access(1'b1, 1'b0, 32'h48, 32'd0, 1'b0, 32'h12345678);
    @(negedge clk);
    chk("hits_after_writes", hit_count, 32'd7);

    // Dirty conflict miss: writeback of the old line, then fill.
    push(K_WR, 32'h40, 128'hDDDDCCCC_12345678_CAFEF00D_22221111);
    push(K_RD, 32'h1040, '0);
    access(1'b1, 1'b0, 32'h1040, 32'd0, 1'b1, 32'hA0A0A0A0);
    push(K_RD, 32'h40, '0);
    access(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, 32'h22221111);
    access(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    chk("conflict_miss_count", miss_count, 32'd3);
    chk("conflict_hit_count", hit_count, 32'd10);

    // Slow memory: stall and address must hold for the whole wait.
    ready_delay = 200;
    push(K_RD, 32'h2050, '0);
    push(K_CPU, 32'h2058, {96'd0, 32'h55550002});
    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_addr = 32'h2058;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_read && cyc < 10);
    if (!mem_read) chk("delay_req_timeout", 32'd1, 32'd0);
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (!cpu_stall || mem_addr !== 32'h2050) bad++;
    end
    chk("delay_hold_bad_cycles", bad, 32'd0);
    cyc = 0;
    while (cpu_stall && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cpu_stall) chk("delay_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    ready_delay = 0;
    @(negedge clk);
    chk("delay_miss_count", miss_count, 32'd4);
    chk("delay_hit_count", hit_count, 32'd11);

    // Reset during FILL_WAIT, then a stale mem_ready after release.
    resp_en = 1'b0;
    push(K_RD, 32'h3070, '0);
    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_addr = 32'h3070;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_read && cyc < 10);
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    cpu_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    kick_n  = kick_n + 1;
    repeat (4) @(negedge clk);
    chk("post_rst_hit_count", hit_count, 32'd0);
    chk("post_rst_miss_count", miss_count, 32'd0);
    chk("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("post_rst_mem_rw", {30'd0, mem_write, mem_read}, 32'd0);
    chk("post_rst_mem_addr", mem_addr, 32'd0);
    resp_en = 1'b1;
    push(K_RD, 32'h3070, '0);
    access(1'b1, 1'b0, 32'h3070, 32'd0, 1'b1, 32'h70707070);
    push(K_RD, 32'h40, '0);
    access(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, 32'h22221111);
    @(negedge clk);
    chk("final_miss_count", miss_count, 32'd2);
    chk("final_hit_count", hit_count, 32'd2);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
